mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Memory-access stage of the five-stage RV32I pipeline, between EX/MEM and MEM/WB. Issues loads and stores to the data-memory port through a request/grant + response-valid handshake, stalls the pipeline while an access is outstanding, and formats load data (lane select, sign/zero extension) into the word the MEM/WB register captures as its memory-data input. Detects misaligned halfword/word accesses and reports them for the trap logic instead of issuing them.

## Interface
- No parameters; data and address width fixed at 32 bits.
- clk  in  1  pipeline clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- mem_valid  in  1  instruction in MEM stage is valid
- mem_read / mem_write  in  1 / 1  load / store; mutually exclusive
- funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU; other codes handled as W
- addr  in  32  effective byte address (ALU result)
- store_data  in  32  rs2 value
- mem_flush  in  1  kill instruction in MEM (trap/redirect)
- dmem_req  out  1  request valid
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word address, bits [1:0] always 0
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_gnt  in  1  request accepted when dmem_req & dmem_gnt
- dmem_rvalid  in  1  load response valid
- dmem_rdata  in  32  load response word
- mem_data_out  out  32  formatted load result
- load_done  out  1  mem_data_out valid this cycle
- mem_stall  out  1  hold IF..MEM, insert bubble into MEM/WB
- misalign_load / misalign_store  out  1 / 1  misaligned access detected

## Operation
- States: IDLE, WAIT_RESP, DONE, DRAIN.
- op = mem_valid & (mem_read|mem_write) & !mem_flush. Misaligned: H/HU with addr[0]=1; W with addr[1:0]≠0. misalign_* combinational in IDLE only, never issued, no stall.
- IDLE: dmem_req = op & !misaligned. Store: we=1; SB be=0001<<addr[1:0], wdata={4{rs2[7:0]}}; SH be=addr[1]?1100:0011, wdata={2{rs2[15:0]}}; SW be=1111, wdata=rs2. Load: we=0, be=1111.
  - store granted → stays IDLE, stage completes that cycle.
  - load granted → register addr[1:0], funct3; go WAIT_RESP.
  - not granted → stay IDLE, request held (upstream keeps inputs stable while stalled).
- WAIT_RESP: dmem_req=0. On rvalid: register formatted data into mem_data_out, go DONE. Flush without rvalid → DRAIN. Flush with rvalid same cycle → discard, go IDLE.
- Formatting: byte = rdata[8*off+:8], half = rdata[16*off[1]+:16]; B/H sign-extend, BU/HU zero-extend, W unchanged.
- DONE: load_done = !mem_flush, mem_stall=0, no request; → IDLE.
- DRAIN: stall=0 (flushed instr is a bubble), no request; on rvalid discard → IDLE.
- rvalid in IDLE/DONE ignored.

## Timing
- Reset: state IDLE; mem_data_out 0; dmem_req, dmem_we, load_done, mem_stall, misalign_* 0; dmem_addr, dmem_be, dmem_wdata 0 while reset high. Reset mid-access abandons it; dmem shares reset.
- mem_stall = (IDLE & op & !misaligned & !(mem_write & dmem_gnt)) | WAIT_RESP.
- Store, immediate grant: 1 cycle, no stall.
- Load, grant cycle T, rvalid T+k (k≥1): stall T..T+k, load_done T+k+1, MEM/WB captures at end of T+k+1. Min 3 stage cycles.
- Request fields stable from first dmem_req until grant.
- At most one outstanding load; next request no earlier than cycle after DONE/DRAIN exit.

## Test plan
- LB addr 0x1003, gnt same cycle, rvalid +1 with 0x80FF_1234 → dmem_addr 0x1000, stall 2 cycles, load_done pulse, mem_data_out 0xFFFF_FF80; LBU same → 0x0000_0080.
- SH addr 0x2002, store_data 0x0000_ABCD, gnt immediate → we=1, dmem_addr 0x2000, be 1100, wdata 0xABCD_ABCD, mem_stall 0.
- LW addr 0x3001 → misalign_load=1, dmem_req 0, stall 0; SW addr 0x3002 → misalign_store=1.
- LHU addr 0x4002, gnt after 3 cycles, rvalid 2 cycles later, rdata 0xBEEF_0000 → req/addr/be stable 4 cycles, stall continuous 6 cycles, mem_data_out 0x0000_BEEF.
- LW granted, mem_flush in WAIT_RESP, rvalid 2 cycles later → DRAIN, load_done never asserts, next load's dmem_req the cycle after drain.
- reset in WAIT_RESP → next edge all outputs 0, state IDLE; later stray rvalid ignored.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM stage of the RV32I pipeline: issues loads/stores over a req/gnt + rvalid
// data-memory handshake, stalls while a load is outstanding, and formats load data.
module mem_access_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic        mem_flush,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] mem_data_out,
  output logic        load_done,
  output logic        mem_stall,
  output logic        misalign_load,
  output logic        misalign_store
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RESP = 2'd1,
    DONE      = 2'd2,
    DRAIN     = 2'd3
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  state_t      state_reg, state_next;
  logic [1:0]  off_reg;
  logic [2:0]  f3_reg;
  logic [31:0] data_reg;

  logic        op;
  logic        is_byte;
  logic        is_half;
  logic        is_word;
  logic        misaligned;
  logic        in_idle;
  logic        issue;
  logic        load_accept;
  logic [3:0]  store_be;
  logic [31:0] store_wdata;
  logic [31:0] fmt_data;

  // Lane select and extension of the returned word, using the offset/size
  // captured when the load was granted.
  function automatic logic [31:0] format_load(input logic [2:0]  f3,
                                              input logic [1:0]  off,
                                              input logic [31:0] rdata);
    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic [31:0] result;
    byte_val = rdata[8*off +: 8];
    half_val = rdata[16*off[1] +: 16];
    case (f3)
      F3_B:    result = {{24{byte_val[7]}}, byte_val};
      F3_BU:   result = {24'h0, byte_val};
      F3_H:    result = {{16{half_val[15]}}, half_val};
      F3_HU:   result = {16'h0, half_val};
      default: result = rdata;
    endcase
    return result;
  endfunction

  always_comb begin
    is_byte    = (funct3 == F3_B) || (funct3 == F3_BU);
    is_half    = (funct3 == F3_H) || (funct3 == F3_HU);
    is_word    = !is_byte && !is_half;
    misaligned = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
    op         = mem_valid && (mem_read || mem_write) && !mem_flush;
    in_idle    = (state_reg == IDLE);
    issue      = !reset && in_idle && op && !misaligned;
    load_accept = issue && mem_read && dmem_gnt;
  end

  always_comb begin
    store_be    = 4'b1111;
    store_wdata = store_data;
    if (is_byte) begin
      store_be    = 4'b0001 << addr[1:0];
      store_wdata = {4{store_data[7:0]}};
    end else if (is_half) begin
      store_be    = addr[1] ? 4'b1100 : 4'b0011;
      store_wdata = {2{store_data[15:0]}};
    end
  end

  // Request fields come straight from the EX/MEM inputs, which upstream holds
  // stable while stalled, so they stay constant until the grant.
  always_comb begin
    dmem_req   = issue;
    dmem_we    = issue && mem_write;
    dmem_addr  = reset ? 32'h0 : {addr[31:2], 2'b00};
    dmem_be    = reset ? 4'h0 : (mem_write ? store_be : 4'b1111);
    dmem_wdata = reset ? 32'h0 : (mem_write ? store_wdata : 32'h0);
  end

  always_comb begin
    misalign_load  = !reset && in_idle && op && misaligned && mem_read;
    misalign_store = !reset && in_idle && op && misaligned && mem_write;
    load_done      = !reset && (state_reg == DONE) && !mem_flush;
    mem_stall      = !reset && ((issue && !(mem_write && dmem_gnt)) ||
                                (state_reg == WAIT_RESP));
    mem_data_out   = data_reg;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (load_accept) state_next = WAIT_RESP;
      end
      WAIT_RESP: begin
        if (dmem_rvalid && mem_flush) state_next = IDLE;
        else if (dmem_rvalid)         state_next = DONE;
        else if (mem_flush)           state_next = DRAIN;
      end
      DONE: begin
        state_next = IDLE;
      end
      DRAIN: begin
        if (dmem_rvalid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign fmt_data = format_load(f3_reg, off_reg, dmem_rdata);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      off_reg   <= 2'b00;
      f3_reg    <= 3'b000;
      data_reg  <= 32'h0;
    end else begin
      state_reg <= state_next;
      if (load_accept) begin
        off_reg <= addr[1:0];
        f3_reg  <= funct3;
      end
      if ((state_reg == WAIT_RESP) && dmem_rvalid && !mem_flush) begin
        data_reg <= fmt_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: loads, stores, misalignment, flush/drain
// and reset-abandon scenarios with hand-computed expectations.
module tb_mem_access_stage;

  logic        clk;
  logic        reset;
  logic        mem_valid;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        mem_flush;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [31:0] mem_data_out;
  logic        load_done;
  logic        mem_stall;
  logic        misalign_load;
  logic        misalign_store;

  int compared;
  int mismatched;

  mem_access_stage dut (
    .clk           (clk),
    .reset         (reset),
    .mem_valid     (mem_valid),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .funct3        (funct3),
    .addr          (addr),
    .store_data    (store_data),
    .mem_flush     (mem_flush),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_be       (dmem_be),
    .dmem_wdata    (dmem_wdata),
    .dmem_gnt      (dmem_gnt),
    .dmem_rvalid   (dmem_rvalid),
    .dmem_rdata    (dmem_rdata),
    .mem_data_out  (mem_data_out),
    .load_done     (load_done),
    .mem_stall     (mem_stall),
    .misalign_load (misalign_load),
    .misalign_store(misalign_store)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  // Advance to one time unit after the next rising edge (input drive point).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_valid   = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    funct3      = 3'b010;
    addr        = 32'h0;
    store_data  = 32'h0;
    mem_flush   = 1'b0;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0;
  endtask

  // Full load: grant after gdly cycles of request, rvalid rdly cycles after grant.
  task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input int gdly, input int rdly, input logic [31:0] rd,
                          input logic [31:0] exp);
    int stall_cnt;
    stall_cnt  = 0;
    mem_valid  = 1'b1;
    mem_read   = 1'b1;
    mem_write  = 1'b0;
    funct3     = f3;
    addr       = a;
    for (int i = 0; i <= gdly; i++) begin
      dmem_gnt = (i == gdly);
      #1;
      check({tag, " req"}, {31'h0, dmem_req}, 32'h1);
      check({tag, " addr"}, dmem_addr, {a[31:2], 2'b00});
      check({tag, " be"}, {28'h0, dmem_be}, 32'hF);
      check({tag, " we"}, {31'h0, dmem_we}, 32'h0);
      if (mem_stall) stall_cnt++;
      tick();
    end
    dmem_gnt = 1'b0;
    for (int j = 1; j <= rdly; j++) begin
      dmem_rvalid = (j == rdly);
      dmem_rdata  = (j == rdly) ? rd : 32'hA5A5_A5A5;
      #1;
      check({tag, " no req wait"}, {31'h0, dmem_req}, 32'h0);
      check({tag, " no done wait"}, {31'h0, load_done}, 32'h0);
      if (mem_stall) stall_cnt++;
      tick();
    end
    dmem_rvalid = 1'b0;
    #1;
    check({tag, " load_done"}, {31'h0, load_done}, 32'h1);
    check({tag, " data"}, mem_data_out, exp);
    check({tag, " stall in done"}, {31'h0, mem_stall}, 32'h0);
    check({tag, " stall cycles"}, stall_cnt, gdly + 1 + rdly);
    mem_valid = 1'b0;
    mem_read  = 1'b0;
    tick();
    check({tag, " done pulse end"}, {31'h0, load_done}, 32'h0);
  endtask

  task automatic run_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] sd, input logic [3:0] exp_be,
                           input logic [31:0] exp_wdata);
    mem_valid  = 1'b1;
    mem_write  = 1'b1;
    mem_read   = 1'b0;
    funct3     = f3;
    addr       = a;
    store_data = sd;
    dmem_gnt   = 1'b1;
    #1;
    check({tag, " req"}, {31'h0, dmem_req}, 32'h1);
    check({tag, " we"}, {31'h0, dmem_we}, 32'h1);
    check({tag, " addr"}, dmem_addr, {a[31:2], 2'b00});
    check({tag, " be"}, {28'h0, dmem_be}, {28'h0, exp_be});
    check({tag, " wdata"}, dmem_wdata, exp_wdata);
    check({tag, " stall"}, {31'h0, mem_stall}, 32'h0);
    tick();
    idle_inputs();
  endtask

  task automatic check_misalign(input string tag, input logic rd, input logic [2:0] f3,
                                input logic [31:0] a, input logic exp_mis);
    mem_valid = 1'b1;
    mem_read  = rd;
    mem_write = !rd;
    funct3    = f3;
    addr      = a;
    dmem_gnt  = 1'b0;
    #1;
    check({tag, " mis_ld"}, {31'h0, misalign_load}, {31'h0, rd & exp_mis});
    check({tag, " mis_st"}, {31'h0, misalign_store}, {31'h0, !rd & exp_mis});
    check({tag, " req"}, {31'h0, dmem_req}, {31'h0, !exp_mis});
    check({tag, " stall"}, {31'h0, mem_stall}, {31'h0, !exp_mis});
    idle_inputs();
    #1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    #1;
    check("rst req", {31'h0, dmem_req}, 32'h0);
    check("rst data", mem_data_out, 32'h0);
    check("rst done", {31'h0, load_done}, 32'h0);
    check("rst stall", {31'h0, mem_stall}, 32'h0);
    reset = 1'b0;
    tick();

    run_load("LB", 3'b000, 32'h0000_1003, 0, 1, 32'h80FF_1234, 32'hFFFF_FF80);
    run_load("LBU", 3'b100, 32'h0000_1003, 0, 1, 32'h80FF_1234, 32'h0000_0080);
    run_load("LH0", 3'b001, 32'h0000_1000, 0, 1, 32'h1234_8001, 32'hFFFF_8001);
    run_load("LHU", 3'b101, 32'h0000_4002, 3, 2, 32'hBEEF_0000, 32'h0000_BEEF);

    run_store("SH", 3'b001, 32'h0000_2002, 32'h0000_ABCD, 4'b1100, 32'hABCD_ABCD);
    run_store("SB", 3'b000, 32'h0000_2001, 32'h1234_5678, 4'b0010, 32'h7878_7878);
    run_store("SW", 3'b010, 32'h0000_2004, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);

    check_misalign("LW 3001", 1'b1, 3'b010, 32'h0000_3001, 1'b1);
    check_misalign("SW 3002", 1'b0, 3'b010, 32'h0000_3002, 1'b1);
    check_misalign("LH 3003", 1'b1, 3'b001, 32'h0000_3003, 1'b1);
    check_misalign("LH 3002", 1'b1, 3'b001, 32'h0000_3002, 1'b0);
    tick();

    // Flush while waiting, response arrives two cycles later in DRAIN.
    mem_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; addr = 32'h0000_5000; dmem_gnt = 1'b1;
    tick();
    dmem_gnt  = 1'b0;
    mem_flush = 1'b1;
    #1;
    check("FL stall wait", {31'h0, mem_stall}, 32'h1);
    tick();
    mem_flush = 1'b0;
    addr      = 32'h0000_6000;
    dmem_gnt  = 1'b1;
    #1;
    check("FL drain req", {31'h0, dmem_req}, 32'h0);
    check("FL drain stall", {31'h0, mem_stall}, 32'h0);
    check("FL drain done", {31'h0, load_done}, 32'h0);
    tick();
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hDEAD_BEEF;
    #1;
    check("FL drain2 req", {31'h0, dmem_req}, 32'h0);
    check("FL drain2 done", {31'h0, load_done}, 32'h0);
    tick();
    dmem_rvalid = 1'b0;
    #1;
    check("FL after req", {31'h0, dmem_req}, 32'h1);
    check("FL after done", {31'h0, load_done}, 32'h0);
    check("FL data kept", mem_data_out, 32'h0000_BEEF);
    tick();
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h1122_3344;
    tick();
    dmem_rvalid = 1'b0;
    #1;
    check("FL next done", {31'h0, load_done}, 32'h1);
    check("FL next data", mem_data_out, 32'h1122_3344);
    idle_inputs();
    tick();

    // Flush and response in the same cycle: discarded, straight back to IDLE.
    mem_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; addr = 32'h0000_7000; dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0; mem_flush = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_AAAA;
    tick();
    idle_inputs();
    #1;
    check("FR done", {31'h0, load_done}, 32'h0);
    check("FR data kept", mem_data_out, 32'h1122_3344);
    mem_valid = 1'b1; mem_read = 1'b1; addr = 32'h0000_7004;
    #1;
    check("FR idle req", {31'h0, dmem_req}, 32'h1);
    idle_inputs();
    tick();

    // Reset while waiting for a response abandons the access.
    mem_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; addr = 32'h0000_8000; dmem_gnt = 1'b1;
    tick();
    mem_read = 1'b0; mem_write = 1'b1; addr = 32'h0000_8001; store_data = 32'hFFFF_FFFF;
    reset = 1'b1;
    #1;
    check("RS req", {31'h0, dmem_req}, 32'h0);
    check("RS addr", dmem_addr, 32'h0);
    check("RS be", {28'h0, dmem_be}, 32'h0);
    check("RS wdata", dmem_wdata, 32'h0);
    check("RS mis_st", {31'h0, misalign_store}, 32'h0);
    check("RS stall", {31'h0, mem_stall}, 32'h0);
    tick();
    check("RS data", mem_data_out, 32'h0);
    reset = 1'b0;
    idle_inputs();
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h9999_9999;
    tick();
    dmem_rvalid = 1'b0;
    #1;
    check("RS stray done", {31'h0, load_done}, 32'h0);
    check("RS stray data", mem_data_out, 32'h0);
    mem_valid = 1'b1; mem_read = 1'b1; addr = 32'h0000_9000;
    #1;
    check("RS idle req", {31'h0, dmem_req}, 32'h1);
    idle_inputs();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
